// File: rtl/irq_timer_bank_if.sv
// Control-side bus of the interrupt timer bank: prescaler/channel configuration,
// interrupt mask and the irq / irq_ack handshake with the control unit.
interface irq_timer_bank_if #(
    parameter int unsigned N_CH    = 4,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned PRESC_W = 8,
    parameter int unsigned ID_W    = 2
);
    logic               presc_we;
    logic [PRESC_W-1:0] presc_val;
    logic               cfg_we;
    logic [ID_W-1:0]    cfg_ch;
    logic [CNT_W-1:0]   cfg_period;
    logic [1:0]         cfg_mode;
    logic [N_CH-1:0]    irq_mask;
    logic               irq_ack;
    logic               irq;
    logic [ID_W-1:0]    irq_id;
    logic [N_CH-1:0]    pending;
    logic [N_CH-1:0]    overrun;
    logic [N_CH-1:0]    active;

    // CPU / control-unit side
    modport master (
        output presc_we, presc_val, cfg_we, cfg_ch, cfg_period, cfg_mode, irq_mask, irq_ack,
        input  irq, irq_id, pending, overrun, active
    );

    // Timer bank side
    modport slave (
        input  presc_we, presc_val, cfg_we, cfg_ch, cfg_period, cfg_mode, irq_mask, irq_ack,
        output irq, irq_id, pending, overrun, active
    );
endinterface

// File: rtl/irq_timer_bank.sv
// Multi-channel down-counter timer bank sharing one prescaler, with pending/overrun
// tracking and a request/acknowledge FSM presenting the lowest unmasked pending channel.
module irq_timer_bank #(
    parameter int unsigned N_CH    = 4,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned PRESC_W = 8,
    parameter int unsigned ID_W    = 2
) (
    input  logic             clk,
    input  logic             reset,
    irq_timer_bank_if.slave  bus
);
    typedef enum logic {IDLE = 1'b0, SERVE = 1'b1} state_t;

    state_t             state_q;
    logic [PRESC_W-1:0] presc_cnt_q;
    logic [PRESC_W-1:0] presc_lim_q;
    logic               tick;

    logic [CNT_W-1:0]   cnt_q    [N_CH];
    logic [CNT_W-1:0]   period_q [N_CH];
    logic [N_CH-1:0]    active_q;
    logic [N_CH-1:0]    oneshot_q;
    logic [N_CH-1:0]    pending_q;
    logic [N_CH-1:0]    overrun_q;

    logic [N_CH-1:0]    cfg_hit;
    logic [N_CH-1:0]    run;
    logic [N_CH-1:0]    expire;
    logic [N_CH-1:0]    ack_clr;
    logic [N_CH-1:0]    req;
    logic [ID_W-1:0]    sel_id;
    logic [ID_W-1:0]    irq_id_q;
    logic               irq_q;
    logic               cfg_active;
    logic               cfg_oneshot;

    assign tick        = (presc_cnt_q == presc_lim_q);
    assign cfg_active  = (bus.cfg_mode == 2'b01) || (bus.cfg_mode == 2'b10);
    assign cfg_oneshot = (bus.cfg_mode == 2'b10);
    assign req         = pending_q & bus.irq_mask;

    // Shared prescaler: tick in the cycle the count reaches the limit
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_cnt_q <= '0;
            presc_lim_q <= '0;
        end else if (bus.presc_we) begin
            presc_lim_q <= bus.presc_val;
            presc_cnt_q <= '0;
        end else if (tick) begin
            presc_cnt_q <= '0;
        end else begin
            presc_cnt_q <= presc_cnt_q + PRESC_W'(1);
        end
    end

    // Per-channel event decode; a configure write masks the tick on its channel
    always_comb begin
        cfg_hit = '0;
        run     = '0;
        expire  = '0;
        ack_clr = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            cfg_hit[i] = bus.cfg_we && (32'(bus.cfg_ch) == i);
            run[i]     = tick && active_q[i] && (period_q[i] != '0) && !cfg_hit[i];
            expire[i]  = run[i] && (cnt_q[i] == CNT_W'(1));
            ack_clr[i] = (state_q == SERVE) && bus.irq_ack && (32'(irq_id_q) == i);
        end
    end

    // Lowest-index unmasked pending channel
    always_comb begin
        sel_id = '0;
        for (int i = int'(N_CH) - 1; i >= 0; i--) begin
            if (req[i]) begin
                sel_id = ID_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                cnt_q[i]    <= '0;
                period_q[i] <= '0;
            end
            active_q  <= '0;
            oneshot_q <= '0;
            pending_q <= '0;
            overrun_q <= '0;
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (cfg_hit[i]) begin
                    cnt_q[i]     <= bus.cfg_period;
                    period_q[i]  <= bus.cfg_period;
                    active_q[i]  <= cfg_active;
                    oneshot_q[i] <= cfg_oneshot;
                    pending_q[i] <= 1'b0;
                    overrun_q[i] <= 1'b0;
                end else if (expire[i]) begin
                    // A simultaneous ack of this channel consumes the old pending, so no overrun
                    pending_q[i] <= 1'b1;
                    overrun_q[i] <= overrun_q[i] | (pending_q[i] & ~ack_clr[i]);
                    if (oneshot_q[i]) begin
                        cnt_q[i]    <= '0;
                        active_q[i] <= 1'b0;
                    end else begin
                        cnt_q[i] <= period_q[i];
                    end
                end else begin
                    if (run[i]) begin
                        cnt_q[i] <= cnt_q[i] - CNT_W'(1);
                    end
                    if (ack_clr[i]) begin
                        pending_q[i] <= 1'b0;
                    end
                end
            end
        end
    end

    // Request/acknowledge FSM; SERVE holds irq_id until the CPU acknowledges
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            irq_q    <= 1'b0;
            irq_id_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        irq_q    <= 1'b1;
                        irq_id_q <= sel_id;
                        state_q  <= SERVE;
                    end
                end
                SERVE: begin
                    if (bus.irq_ack) begin
                        irq_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    irq_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.irq     = irq_q;
    assign bus.irq_id  = irq_id_q;
    assign bus.pending = pending_q;
    assign bus.overrun = overrun_q;
    assign bus.active  = active_q;
endmodule

// File: tb/tb_irq_timer_bank.sv
// Directed bench for irq_timer_bank: inputs driven and outputs sampled on the falling edge.
module tb_irq_timer_bank;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    irq_timer_bank_if bus ();

    irq_timer_bank dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cfg(input int ch, input int period, input logic [1:0] mode);
        bus.cfg_we     = 1'b1;
        bus.cfg_ch     = 2'(ch);
        bus.cfg_period = 8'(period);
        bus.cfg_mode   = mode;
        @(negedge clk);
        bus.cfg_we     = 1'b0;
    endtask

    task automatic ack();
        bus.irq_ack = 1'b1;
        @(negedge clk);
        bus.irq_ack = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_irq"},     32'(bus.irq),     0);
        check({tag, "_irq_id"},  32'(bus.irq_id),  0);
        check({tag, "_pending"}, 32'(bus.pending), 0);
        check({tag, "_overrun"}, 32'(bus.overrun), 0);
        check({tag, "_active"},  32'(bus.active),  0);
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        reset          = 1'b1;
        bus.presc_we   = 1'b0;
        bus.presc_val  = '0;
        bus.cfg_we     = 1'b0;
        bus.cfg_ch     = '0;
        bus.cfg_period = '0;
        bus.cfg_mode   = 2'b00;
        bus.irq_mask   = '0;
        bus.irq_ack    = 1'b0;
        step(2);
        check_all_zero("reset");
        reset        = 1'b0;
        bus.irq_mask = 4'hF;

        // ch0 periodic, period 3, prescaler 0
        cfg(0, 3, 2'b01);
        step(2);
        check("t1_pend_early", 32'(bus.pending), 0);
        step(1);
        check("t1_pend",       32'(bus.pending), 1);
        check("t1_irq_lat",    32'(bus.irq),     0);
        step(1);
        check("t1_irq",        32'(bus.irq),     1);
        check("t1_id",         32'(bus.irq_id),  0);
        ack();
        check("t1_ack_irq",    32'(bus.irq),     0);
        check("t1_ack_pend",   32'(bus.pending), 0);
        step(1);
        check("t1_pend2",      32'(bus.pending), 1);
        step(1);
        check("t1_irq2",       32'(bus.irq),     1);
        check("t1_id2",        32'(bus.irq_id),  0);
        ack();
        check("t1_ack2_irq",   32'(bus.irq),     0);
        cfg(0, 0, 2'b00);
        check("t1_off_pend",   32'(bus.pending), 0);
        check("t1_off_act",    32'(bus.active),  0);

        // ch1/ch2 period 4 expire together behind a divide-by-2 prescaler
        bus.presc_we  = 1'b1;
        bus.presc_val = 8'd1;
        cfg(1, 4, 2'b01);
        bus.presc_we  = 1'b0;
        cfg(2, 4, 2'b01);
        check("t2_act",        32'(bus.active),  'h6);
        step(6);
        check("t2_pend_early", 32'(bus.pending), 0);
        step(1);
        check("t2_pend",       32'(bus.pending), 'h6);
        check("t2_irq_lat",    32'(bus.irq),     0);
        step(1);
        check("t2_irq1",       32'(bus.irq),     1);
        check("t2_id1",        32'(bus.irq_id),  1);
        ack();
        check("t2_idle_irq",   32'(bus.irq),     0);
        check("t2_idle_pend",  32'(bus.pending), 'h4);
        step(1);
        check("t2_irq2",       32'(bus.irq),     1);
        check("t2_id2",        32'(bus.irq_id),  2);
        ack();
        check("t2_done_irq",   32'(bus.irq),     0);
        check("t2_done_pend",  32'(bus.pending), 0);
        cfg(1, 0, 2'b00);
        cfg(2, 0, 2'b00);
        check("t2_off_act",    32'(bus.active),  0);

        // ch3 one-shot, period 2, prescaler 4
        bus.presc_we  = 1'b1;
        bus.presc_val = 8'd4;
        cfg(3, 2, 2'b10);
        bus.presc_we  = 1'b0;
        step(9);
        check("t3_pend_early", 32'(bus.pending), 0);
        check("t3_act_early",  32'(bus.active),  'h8);
        step(1);
        check("t3_pend",       32'(bus.pending), 'h8);
        check("t3_act",        32'(bus.active),  0);
        step(1);
        check("t3_irq",        32'(bus.irq),     1);
        check("t3_id",         32'(bus.irq_id),  3);
        ack();
        step(100);
        check("t3_quiet_pend", 32'(bus.pending), 0);
        check("t3_quiet_irq",  32'(bus.irq),     0);
        check("t3_quiet_ovr",  32'(bus.overrun), 0);

        // ch0 period 1, masked: overrun on second expiry, no irq
        bus.presc_we  = 1'b1;
        bus.presc_val = 8'd0;
        bus.irq_mask  = 4'h0;
        cfg(0, 1, 2'b01);
        bus.presc_we  = 1'b0;
        step(1);
        check("t4_pend1",      32'(bus.pending), 1);
        check("t4_ovr1",       32'(bus.overrun), 0);
        step(1);
        check("t4_ovr2",       32'(bus.overrun), 1);
        check("t4_irq",        32'(bus.irq),     0);
        cfg(0, 0, 2'b00);
        check("t4_clr_pend",   32'(bus.pending), 0);
        check("t4_clr_ovr",    32'(bus.overrun), 0);

        // masked pending survives an ack in IDLE and is served once unmasked
        cfg(0, 1, 2'b10);
        step(1);
        check("t4m_pend",      32'(bus.pending), 1);
        check("t4m_act",       32'(bus.active),  0);
        ack();
        step(2);
        check("t4m_keep",      32'(bus.pending), 1);
        check("t4m_noirq",     32'(bus.irq),     0);
        bus.irq_mask = 4'h1;
        step(1);
        check("t4m_irq",       32'(bus.irq),     1);
        check("t4m_id",        32'(bus.irq_id),  0);
        ack();
        check("t4m_ack_pend",  32'(bus.pending), 0);

        // reset while irq is asserted
        bus.irq_mask = 4'hF;
        cfg(0, 2, 2'b01);
        step(3);
        check("t5_irq",        32'(bus.irq),     1);
        reset = 1'b1;
        step(1);
        check_all_zero("t5_rst");
        reset = 1'b0;
        step(10);
        check("t5_quiet_pend", 32'(bus.pending), 0);
        check("t5_quiet_irq",  32'(bus.irq),     0);

        // ack coincident with a new expiry of the served channel
        cfg(0, 2, 2'b01);
        step(3);
        check("t6_irq",        32'(bus.irq),     1);
        check("t6_id",         32'(bus.irq_id),  0);
        ack();
        check("t6_ack_irq",    32'(bus.irq),     0);
        check("t6_ack_pend",   32'(bus.pending), 1);
        check("t6_ack_ovr",    32'(bus.overrun), 0);
        step(1);
        check("t6_reirq",      32'(bus.irq),     1);
        // configure the served channel: pending clears, request held
        cfg(0, 5, 2'b01);
        check("t6_cfg_pend",   32'(bus.pending), 0);
        check("t6_cfg_irq",    32'(bus.irq),     1);
        ack();
        check("t6_end_irq",    32'(bus.irq),     0);
        step(1);
        check("t6_end_idle",   32'(bus.irq),     0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
